// File: rtl/disl_priority_arbiter.sv
// disl_priority_arbiter
// Registered request arbiter with a held grant. It issues a one-hot grant and a
// binary index, and holds that grant until the owner releases it or withdraws.
// Supported policies: fixed MSB-first, fixed LSB-first and round-robin.
// WIDTH can be any value of 1 or more; it does not need to be a power of two.
// Every output comes from a flop, so there is no combinational path from
// request_i to any output.

module disl_priority_arbiter #(
    parameter int    WIDTH = 8,
    parameter string MODE  = "MSB",
    localparam int   IDX_W = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] request_i,
    input  logic             release_i,
    output logic [WIDTH-1:0] grant_o,
    output logic [IDX_W-1:0] grant_index_o,
    output logic             grant_valid_o,
    output logic             grant_start_o
);

    // Policy selector: 0 = MSB-first, 1 = LSB-first, 2 = round-robin.
    // An unrecognised MODE string falls back to MSB-first.
    localparam int MODE_SEL = (MODE == "LSB") ? 1 :
                              (MODE == "RR")  ? 2 : 0;
    localparam bit IS_RR    = (MODE_SEL == 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               start_q, start_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;

    logic               ownerHolds;
    logic               handoff;
    logic [WIDTH-1:0]   eligible;
    logic               anyEligible;
    logic [IDX_W-1:0]   msbIdx;
    logic [IDX_W-1:0]   lsbIdx;
    logic [IDX_W-1:0]   rrIdx;
    logic [IDX_W-1:0]   winIdx;
    logic [IDX_W-1:0]   nextPtr;

    // Highest set bit. The loop runs upward, so a later (higher) hit
    // overwrites an earlier one.
    function automatic logic [IDX_W-1:0] findMsb(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Lowest set bit. The loop runs downward, so the lowest hit is written last.
    function automatic logic [IDX_W-1:0] findLsb(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Round-robin search starting at ptr. The function looks for the lowest set
    // bit at or above ptr; if there is none, it takes the lowest set bit overall.
    // This gives the wrap modulo WIDTH without any modular arithmetic, which
    // keeps non-power-of-two widths correct.
    function automatic logic [IDX_W-1:0] findRr(input logic [WIDTH-1:0] vec,
                                                input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] hiIdx;
        logic [IDX_W-1:0] loIdx;
        logic             hiFound;
        hiIdx   = '0;
        loIdx   = '0;
        hiFound = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                loIdx = IDX_W'(i);
                if (i >= int'(ptr)) begin
                    hiIdx   = IDX_W'(i);
                    hiFound = 1'b1;
                end
            end
        end
        return hiFound ? hiIdx : loIdx;
    endfunction

    // Winner selection: decide whether the current owner is finished, mask the
    // owner out of the eligible set, and pick a winner under the chosen policy.
    always_comb begin
        ownerHolds  = |(grant_q & request_i);
        handoff     = (state_q == BUSY) && (release_i || !ownerHolds);
        eligible    = (state_q == BUSY) ? (request_i & ~grant_q) : request_i;
        anyEligible = |eligible;
        msbIdx      = findMsb(eligible);
        lsbIdx      = findLsb(eligible);
        rrIdx       = findRr(eligible, ptr_q);
        case (MODE_SEL)
            1:       winIdx = lsbIdx;
            2:       winIdx = rrIdx;
            default: winIdx = msbIdx;
        endcase
        if (int'(winIdx) == WIDTH - 1) begin
            nextPtr = '0;
        end else begin
            nextPtr = winIdx + IDX_W'(1);
        end
    end

    // Next-state logic: start a new grant, hand off back-to-back, hold, or go idle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        index_d = index_q;
        start_d = 1'b0;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (anyEligible) begin
                    state_d = BUSY;
                    grant_d = WIDTH'(1) << winIdx;
                    index_d = winIdx;
                    start_d = 1'b1;
                    if (IS_RR) begin
                        ptr_d = nextPtr;
                    end
                end
            end
            BUSY: begin
                if (handoff) begin
                    if (anyEligible) begin
                        state_d = BUSY;
                        grant_d = WIDTH'(1) << winIdx;
                        index_d = winIdx;
                        start_d = 1'b1;
                        if (IS_RR) begin
                            ptr_d = nextPtr;
                        end
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        index_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                index_d = '0;
            end
        endcase
    end

    // State and output registers. Reset is asynchronous, so a mid-grant reset
    // drops the grant immediately without waiting for a clock edge.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            index_q <= '0;
            start_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            start_q <= start_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_index_o = index_q;
    assign grant_valid_o = (state_q == BUSY);
    assign grant_start_o = start_q;

endmodule

// File: tb/tb_disl_priority_arbiter.sv
// Testbench for disl_priority_arbiter.
// Three instances are exercised side by side:
//   - MSB-first, WIDTH 8
//   - LSB-first, WIDTH 8
//   - round-robin, WIDTH 5
// A queue-free reference model runs alongside them, using modular arithmetic
// for the round-robin search. Hand-built tables cover the scripted corner
// cases, and a randomized phase follows them.

module tb_disl_priority_arbiter;

    logic       clock;
    logic       reset_n;
    logic [7:0] reqV [3];
    logic       relV [3];

    logic [7:0] gnt0, gnt1;
    logic [4:0] gnt2;
    logic [2:0] idx0, idx1, idx2;
    logic       val0, val1, val2;
    logic       st0, st1, st2;

    int total;
    int bad;

    // Reference model state: owner index (-1 when idle), RR pointer, start pulse.
    int ownM   [3];
    int ptrM   [3];
    int startM [3];

    // Per-instance configuration: policy (0 = MSB, 1 = LSB, 2 = RR) and width.
    int modeOf [3] = '{0, 1, 2};
    int widthOf[3] = '{8, 8, 5};

    typedef struct {
        logic [7:0] req;
        logic       rel;
        int         idx;
        logic       valid;
        logic       start;
    } vec_t;

    vec_t lsbTbl [13];
    vec_t rrTbl  [10];

    disl_priority_arbiter #(.WIDTH(8), .MODE("MSB")) uMsb (
        .clock_i(clock), .reset_n_i(reset_n), .request_i(reqV[0]), .release_i(relV[0]),
        .grant_o(gnt0), .grant_index_o(idx0), .grant_valid_o(val0), .grant_start_o(st0)
    );

    disl_priority_arbiter #(.WIDTH(8), .MODE("LSB")) uLsb (
        .clock_i(clock), .reset_n_i(reset_n), .request_i(reqV[1]), .release_i(relV[1]),
        .grant_o(gnt1), .grant_index_o(idx1), .grant_valid_o(val1), .grant_start_o(st1)
    );

    disl_priority_arbiter #(.WIDTH(5), .MODE("RR")) uRr (
        .clock_i(clock), .reset_n_i(reset_n), .request_i(reqV[2][4:0]), .release_i(relV[2]),
        .grant_o(gnt2), .grant_index_o(idx2), .grant_valid_o(val2), .grant_start_o(st2)
    );

    // Free-running clock with a 10-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit, so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Return the winner for a request vector under the given policy, or -1 if
    // no bit is set.
    function automatic int pick(input int mode, input int w, input int vec, input int ptr);
        if (vec == 0) return -1;
        if (mode == 0) begin
            for (int i = w - 1; i >= 0; i--) if (((vec >> i) & 1) == 1) return i;
        end else if (mode == 1) begin
            for (int i = 0; i < w; i++) if (((vec >> i) & 1) == 1) return i;
        end else begin
            for (int k = 0; k < w; k++) begin
                int j;
                j = (ptr + k) % w;
                if (((vec >> j) & 1) == 1) return j;
            end
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int n = 0; n < 3; n++) begin
            ownM[n]   = -1;
            ptrM[n]   = 0;
            startM[n] = 0;
        end
    endtask

    // Advance the model of instance n by one clock, using the inputs as they
    // are currently driven.
    task automatic modelStep(input int n);
        int w;
        int req;
        int elig;
        int win;
        bit arb;
        w         = widthOf[n];
        req       = int'(reqV[n]) & ((1 << w) - 1);
        startM[n] = 0;
        arb       = 1'b0;
        elig      = 0;
        if (ownM[n] < 0) begin
            elig = req;
            arb  = 1'b1;
        end else if (relV[n] || (((req >> ownM[n]) & 1) == 0)) begin
            elig = req & ~(1 << ownM[n]);
            arb  = 1'b1;
        end
        if (arb) begin
            win = pick(modeOf[n], w, elig, ptrM[n]);
            if (win >= 0) begin
                ownM[n]   = win;
                startM[n] = 1;
                if (modeOf[n] == 2) ptrM[n] = (win + 1) % w;
            end else begin
                ownM[n] = -1;
            end
        end
    endtask

    // Compare every output of instance n against the model.
    task automatic checkOutput(input int n);
        int aG, aI, aV, aS;
        int eG, eI, eV;
        case (n)
            0:       begin aG = int'(gnt0); aI = int'(idx0); aV = int'(val0); aS = int'(st0); end
            1:       begin aG = int'(gnt1); aI = int'(idx1); aV = int'(val1); aS = int'(st1); end
            default: begin aG = int'(gnt2); aI = int'(idx2); aV = int'(val2); aS = int'(st2); end
        endcase
        eG = (ownM[n] < 0) ? 0 : (1 << ownM[n]);
        eI = (ownM[n] < 0) ? 0 : ownM[n];
        eV = (ownM[n] < 0) ? 0 : 1;
        check($sformatf("inst%0d grant", n), aG, eG);
        check($sformatf("inst%0d index", n), aI, eI);
        check($sformatf("inst%0d valid", n), aV, eV);
        check($sformatf("inst%0d start", n), aS, startM[n]);
    endtask

    // One clock: step the model, take the edge, then sample 2 units after it.
    task automatic applyStimulus();
        for (int n = 0; n < 3; n++) modelStep(n);
        @(posedge clock);
        #2;
        for (int n = 0; n < 3; n++) checkOutput(n);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // LSB-first: hold against a lower-index requester, back-to-back
        // handoffs, implicit release, release while idle, and the idle return.
        lsbTbl[0]  = '{8'b0000_0110, 1'b0, 1, 1'b1, 1'b1};
        lsbTbl[1]  = '{8'b0000_0111, 1'b0, 1, 1'b1, 1'b0};
        lsbTbl[2]  = '{8'b0000_0111, 1'b0, 1, 1'b1, 1'b0};
        lsbTbl[3]  = '{8'b0000_0111, 1'b0, 1, 1'b1, 1'b0};
        lsbTbl[4]  = '{8'b0000_0111, 1'b0, 1, 1'b1, 1'b0};
        lsbTbl[5]  = '{8'b0000_0111, 1'b0, 1, 1'b1, 1'b0};
        lsbTbl[6]  = '{8'b0000_0111, 1'b1, 0, 1'b1, 1'b1};
        lsbTbl[7]  = '{8'b0000_0111, 1'b0, 0, 1'b1, 1'b0};
        lsbTbl[8]  = '{8'b0000_0111, 1'b1, 1, 1'b1, 1'b1};
        lsbTbl[9]  = '{8'b0000_0000, 1'b0, 0, 1'b0, 1'b0};
        lsbTbl[10] = '{8'b0000_0100, 1'b1, 2, 1'b1, 1'b1};
        lsbTbl[11] = '{8'b0000_0100, 1'b1, 0, 1'b0, 1'b0};
        lsbTbl[12] = '{8'b0000_0100, 1'b0, 2, 1'b1, 1'b1};

        // Round-robin at WIDTH 5: the index wraps at 5 (not 8), then an
        // implicit release moves the pointer to 1.
        rrTbl[0] = '{8'b0001_1111, 1'b0, 0, 1'b1, 1'b1};
        rrTbl[1] = '{8'b0001_1111, 1'b1, 1, 1'b1, 1'b1};
        rrTbl[2] = '{8'b0001_1111, 1'b1, 2, 1'b1, 1'b1};
        rrTbl[3] = '{8'b0001_1111, 1'b1, 3, 1'b1, 1'b1};
        rrTbl[4] = '{8'b0001_1111, 1'b1, 4, 1'b1, 1'b1};
        rrTbl[5] = '{8'b0001_1111, 1'b1, 0, 1'b1, 1'b1};
        rrTbl[6] = '{8'b0001_1111, 1'b1, 1, 1'b1, 1'b1};
        rrTbl[7] = '{8'b0001_1111, 1'b1, 2, 1'b1, 1'b1};
        rrTbl[8] = '{8'b0000_0001, 1'b0, 0, 1'b1, 1'b1};
        rrTbl[9] = '{8'b0001_1111, 1'b1, 1, 1'b1, 1'b1};

        // Hold reset with every requester asserted; all outputs must stay 0.
        reset_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            reqV[n] = 8'hFF;
            relV[n] = 1'b0;
        end
        modelReset();
        #12;
        for (int n = 0; n < 3; n++) checkOutput(n);

        // Release reset between edges; MSB grants bit 7 on the very next edge.
        reqV[1] = 8'h00;
        reqV[2] = 8'h00;
        reset_n = 1'b1;
        applyStimulus();
        check("msb first grant", int'(gnt0), 8'h80);
        check("msb first index", int'(idx0), 7);
        check("msb first start", int'(st0), 1);
        applyStimulus();
        check("msb start one cycle", int'(st0), 0);
        reqV[0] = 8'h00;
        applyStimulus();

        for (int i = 0; i < 13; i++) begin
            reqV[1] = lsbTbl[i].req;
            relV[1] = lsbTbl[i].rel;
            applyStimulus();
            check($sformatf("lsbTbl[%0d] index", i), int'(idx1), lsbTbl[i].idx);
            check($sformatf("lsbTbl[%0d] valid", i), int'(val1), int'(lsbTbl[i].valid));
            check($sformatf("lsbTbl[%0d] start", i), int'(st1), int'(lsbTbl[i].start));
        end
        reqV[1] = 8'h00;
        relV[1] = 1'b0;

        for (int i = 0; i < 10; i++) begin
            reqV[2] = rrTbl[i].req;
            relV[2] = rrTbl[i].rel;
            applyStimulus();
            check($sformatf("rrTbl[%0d] index", i), int'(idx2), rrTbl[i].idx);
            check($sformatf("rrTbl[%0d] valid", i), int'(val2), int'(rrTbl[i].valid));
            check($sformatf("rrTbl[%0d] start", i), int'(st2), int'(rrTbl[i].start));
        end

        // Reset mid-grant, between edges: the grant must drop before the next edge.
        relV[2] = 1'b0;
        applyStimulus();
        check("rr held before reset", int'(val2), 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset grant", int'(gnt2), 0);
        check("async reset valid", int'(val2), 0);
        check("async reset index", int'(idx2), 0);
        modelReset();
        #1;
        reset_n = 1'b1;
        applyStimulus();
        check("rr restart index", int'(idx2), 0);
        check("rr restart start", int'(st2), 1);

        // Randomized phase. Request vectors are sticky, so grants get held for
        // several cycles; releases are pulsed about a quarter of the time.
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(0, 3) == 0) reqV[n] = 8'($urandom);
                relV[n] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
